instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  - Requester side of the instruction-memory read interface: owns the PC, drives the
//    word address into instruction memory and captures the returned 16-bit instruction.
//  - Memory returns data one clock after the address is sampled (registered read).
//  - Feeds decode through a valid/ready handshake and accepts branch/jump redirects.
//  - Sits between the PC-select logic and the IF/ID boundary of the pipeline.
// PARAMETERS
//  - ADDR_W    16       instruction word-address width
//  - INSTR_W   16       instruction width
//  - RESET_PC  16'h0000 first address fetched after reset
// PORTS
//  - clk            in   1        clock; all state updates on posedge
//  - rst_n          in   1        asynchronous reset, active-low
//  - imem_addr      out  ADDR_W   word address to instruction memory
//  - imem_instr     in   INSTR_W  memory data for the address presented the previous cycle
//  - redirect_valid in   1        branch/jump taken this cycle
//  - redirect_pc    in   ADDR_W   redirect target
//  - id_ready       in   1        decode accepts if_instr this cycle
//  - if_valid       out  1        if_instr/if_pc hold a valid fetched instruction
//  - if_instr       out  INSTR_W  fetched instruction
//  - if_pc          out  ADDR_W   address of if_instr
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc_q=RESET_PC; inflight=0; skid_valid=0; if_valid=0;
//    if_instr=0; if_pc=0. imem_addr follows pc_q, so it reads RESET_PC during reset.
//  - imem_addr = pc_q (combinational). issue = !skid_valid && !(if_valid && !id_ready)
//    && !redirect_valid.
//  - On issue: pc_q<=pc_q+1 (mod 2^ADDR_W; 16'hFFFF wraps to 0); inflight<=1;
//    req_pc<=pc_q. With no issue: inflight<=0; pc_q holds.
//  - Response: when inflight=1, imem_instr belongs to req_pc. If the output stage is
//    empty or being consumed (!if_valid || id_ready), and the skid buffer is empty,
//    it loads the output stage. Otherwise it loads the skid buffer.
//  - Consume (if_valid && id_ready): if skid_valid, output<=skid and skid_valid<=0.
//    Otherwise, if a response arrives, output<=response. Otherwise if_valid<=0.
//  - Stall: if_valid && !id_ready holds if_instr/if_pc stable for as long as ready
//    stays low. At most one in-flight response is absorbed by the skid buffer.
//    No further issue occurs until both stall and skid drain.
//  - Latency: first if_valid is 2 cycles after rst_n deasserts (RESET_PC). Redirect
//    sampled at edge N gives if_valid with if_pc=redirect_pc after edge N+2.
//  - Streaming without stalls: one instruction per cycle, consecutive if_pc values.
//  - Redirect (priority over everything): pc_q<=redirect_pc; inflight<=0 (the
//    response arriving next cycle is dropped); skid_valid<=0; if_valid<=0.
//    This applies even when if_valid && !id_ready. Redirect plus consume in the same
//    cycle still counts the current if_instr as consumed.
//  - Back-to-back redirects: the last one wins. No instruction from an earlier
//    target is ever presented.
//  - Reset mid-operation: all state is cleared immediately. The in-flight response
//    is discarded.
//  - No FSM beyond the control bits {inflight, skid_valid, if_valid}. The design
//    must never produce if_valid=0 && skid_valid=1.
// CONFIGURATION
//  - IFU_PERF_CNT_EN defined: adds ports perf_fetch_cnt (out, 16) and
//    perf_stall_cnt (out, 16). Both reset to 0 and saturate at 16'hFFFF.
//    perf_fetch_cnt counts accepted handshakes (if_valid && id_ready).
//    perf_stall_cnt counts cycles with if_valid && !id_ready.
//  - IFU_PERF_CNT_EN undefined: the ports and counters are absent. All other
//    behaviour is identical.
// TESTING
//  - Reset release, mem[0..3]=16'h1111,16'h2222,16'h3333,16'h4444, id_ready=1 ->
//    if_valid after 2nd edge; if_pc 0,1,2,3 with matching instrs on consecutive cycles.
//  - id_ready=0 for 3 cycles while if_pc=1 -> if_instr=16'h2222 held; after release
//    the outputs are 2,3 in order with no loss or duplicate.
//  - redirect_valid=1, redirect_pc=16'h0040 while streaming -> next valid is
//    if_pc=16'h0040 two edges later; the in-flight word is never presented.
//  - Redirect asserted during a stall with skid full -> stalled and skid words are
//    dropped; next valid is if_pc=redirect_pc.
//  - RESET_PC=16'hFFFE -> if_pc sequence FFFE, FFFF, 0000, 0001.
//  - rst_n pulsed low mid-stream -> if_valid=0 immediately; the fetch restarts at RESET_PC.
//    With IFU_PERF_CNT_EN: after 5 accepts and 3 stall cycles, counters read 5 and 3.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and fetch stage with a one-entry skid buffer and a valid/ready output.
// Define IFU_PERF_CNT_EN to add the saturating fetch and stall performance counters.
module instruction_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt,
`endif
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);
    logic [ADDR_W-1:0]  pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d, if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d, if_instr_q, if_instr_d;
    logic               inflight_q, inflight_d, skid_valid_q, skid_valid_d, if_valid_q, if_valid_d;
    logic               stall, consume, issue;

    always_comb begin
        stall = if_valid_q && !id_ready;
        consume = if_valid_q && id_ready;
        issue = !skid_valid_q && !stall && !redirect_valid;
        pc_d = issue ? pc_q + 1'b1 : pc_q;
        inflight_d = issue;
        req_pc_d = issue ? pc_q : req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d = skid_pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d = if_pc_q;
        if (consume && skid_valid_q) begin
            if_instr_d = skid_instr_q;
            if_pc_d = skid_pc_q;
            skid_valid_d = inflight_q;
            skid_instr_d = imem_instr;
            skid_pc_d = req_pc_q;
        end else if (inflight_q && !stall) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_instr;
            if_pc_d = req_pc_q;
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_instr;
            skid_pc_d = req_pc_q;
        end else if (consume) begin
            if_valid_d = 1'b0;
        end
        // A redirect kills everything older, including the response due next cycle.
        if (redirect_valid) begin
            pc_d = redirect_pc;
            inflight_d = 1'b0;
            skid_valid_d = 1'b0;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            req_pc_q <= '0;
            inflight_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
            inflight_q <= inflight_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q <= skid_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc = if_pc_q;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = (consume && perf_fetch_q != 16'hFFFF) ? perf_fetch_q + 16'd1 : perf_fetch_q;
        perf_stall_d = (stall && perf_stall_q != 16'hFFFF) ? perf_stall_q + 16'd1 : perf_stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench with a scoreboard of expected accepted {pc, instr} pairs.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid = 1'b0, id_ready = 1'b1;
    logic [15:0] redirect_pc = '0;
    logic [15:0] imem_addr, imem_instr = '0, if_instr, if_pc;
    logic        if_valid;
    logic [15:0] imem_addr2, imem_instr2 = '0, if_instr2, if_pc2;
    logic        if_valid2;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt2, perf_stall_cnt2;
`endif
    int n_assert = 0, n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(16'h0000), .id_ready(1'b1),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt2), .perf_stall_cnt(perf_stall_cnt2),
`endif
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a < 16'd4) ? (a + 16'd1) * 16'h1111 : a ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        imem_instr <= mem_word(imem_addr);
        imem_instr2 <= mem_word(imem_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] p);
        exp_q.push_back({p, mem_word(p)});
    endtask

    task automatic wait_pc(input logic [15:0] p);
        bit found = 0;
        id_ready = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (if_valid && if_pc == p) begin
                id_ready = 1'b0;
                found = 1;
            end
        end
        chk("wait_pc_found", {31'd0, found}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL extra_accept: observed pc %h expected no accept", if_pc);
            end
            if (exp_q.size() > 0) chk("accept", {if_pc, if_instr}, exp_q.pop_front());
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", {16'd0, if_instr}, 32'd0);
        chk("rst_pc", {16'd0, if_pc}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'd0);
        chk("rst_addr2", {16'd0, imem_addr2}, 32'h0000FFFE);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf", {perf_fetch_cnt, perf_stall_cnt}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) push(16'(i));
        rst_n = 1'b1;
        tick();
        chk("lat_edge1", {31'd0, if_valid}, 32'd0);
        tick();
        chk("lat_edge2", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0000});
        chk("wrap_fffe", {15'd0, if_valid2, if_pc2}, {15'd0, 1'b1, 16'hFFFE});
        tick();
        chk("stream_pc1", {if_pc, if_instr}, {16'h0001, 16'h2222});
        chk("wrap_ffff", {if_pc2, if_instr2}, {16'hFFFF, mem_word(16'hFFFF)});
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", {15'd0, if_valid, if_pc, if_instr}, {15'd0, 1'b1, 16'h0001, 16'h2222});
            if (i == 0) chk("wrap_0000", {if_pc2, if_instr2}, {16'h0000, 16'h1111});
            if (i == 1) chk("wrap_0001", {if_pc2, if_instr2}, {16'h0001, 16'h2222});
        end
        wait_pc(16'h0005);
        chk("drain_stall", exp_q.size(), 32'd0);
        tick();
        push(16'h0080);
        push(16'h0081);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        chk("rdr_skid_kill", {31'd0, if_valid}, 32'd0);
        tick();
        chk("rdr_skid_n1", {31'd0, if_valid}, 32'd0);
        tick();
        chk("rdr_skid_n2", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0080});
        tick();
        chk("rdr_stream", {if_pc, if_instr}, {16'h0081, mem_word(16'h0081)});
        for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        chk("rdr_kill", {31'd0, if_valid}, 32'd0);
        tick();
        chk("rdr_n1", {31'd0, if_valid}, 32'd0);
        tick();
        chk("rdr_n2", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0040});
        wait_pc(16'h0044);
        chk("drain_rdr", exp_q.size(), 32'd0);
        push(16'h0020);
        push(16'h0021);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        wait_pc(16'h0022);
        chk("drain_b2b", exp_q.size(), 32'd0);
        push(16'h0022);
        id_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, if_valid, if_pc}, 32'd0);
        chk("midrst_addr", {16'd0, imem_addr}, 32'd0);
        for (int i = 0; i < 5; i++) push(16'(i));
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_edge1", {31'd0, if_valid}, 32'd0);
        tick();
        chk("restart_pc0", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0000});
        for (int i = 0; i < 4; i++) tick();
        id_ready = 1'b0;
        chk("perf_pc4", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0004});
        for (int i = 0; i < 3; i++) tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
        chk("perf_counts", {perf_fetch_cnt, perf_stall_cnt}, {16'd5, 16'd3});
`endif
        chk("drain_final", exp_q.size(), 32'd0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
